l4_cmd_fifo: RTL and testbench

- Command queue sitting directly upstream of the 32x32 routing accelerator's control FSM.
- Accepts 32-bit command words from the PCI host-side write path and presents them first-word-fall-through on the accelerator's cmd_empty / cmd_in / cmd_rd interface.
- Provides a full indication to the host, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags for the status path.

---
 rtl/l4_cmd_fifo.sv | 109 ++++++++++
 tb/tb_l4_cmd_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l4_cmd_fifo.sv
// First-word-fall-through command queue feeding the routing accelerator's control FSM.
// Optional registered almost-full flag is built when L4_CMD_FIFO_AFULL_EN is defined.
module l4_cmd_fifo #(
    parameter int WIDTH     = 32,
    parameter int ABITS     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             host_wr,
    input  logic [WIDTH-1:0] host_data,
    output logic             host_full,
    output logic             host_afull,
    input  logic             flush,
    output logic             cmd_empty,
    output logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_rd,
    output logic [ABITS:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH   = 2 ** ABITS;
    localparam logic [ABITS:0] L_DEPTH = (ABITS + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ABITS-1:0] r_wr_ptr;
    logic [ABITS-1:0] r_rd_ptr;
    logic [ABITS:0]   r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_we;
    logic             w_re;
    logic [ABITS:0]   w_level_nxt;

    assign cmd_empty = (r_level == '0);
    assign host_full = (r_level == L_DEPTH);
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    assign w_we = host_wr & ~host_full & ~flush;
    assign w_re = cmd_rd & ~cmd_empty & ~flush;

    // Head word is shown combinationally; zero when nothing is queued.
    assign cmd_data = cmd_empty ? '0 : r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        if (flush)
            w_level_nxt = '0;
        else if (w_we && !w_re)
            w_level_nxt = r_level + 1'b1;
        else if (w_re && !w_we)
            w_level_nxt = r_level - 1'b1;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_ptr] <= host_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            if (w_we)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_re)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (host_wr && host_full)
                r_overflow <= 1'b1;
            if (cmd_rd && cmd_empty)
                r_underflow <= 1'b1;
        end
    end

`ifdef L4_CMD_FIFO_AFULL_EN
    localparam logic [ABITS:0] L_AF_THRESH = (ABITS + 1)'(DEPTH - AF_MARGIN);

    logic r_afull;

    // Computed from the next level so the flag moves in the same cycle as level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_afull <= 1'b0;
        else
            r_afull <= (w_level_nxt >= L_AF_THRESH);
    end

    assign host_afull = r_afull;
`else
    assign host_afull = 1'b0;
`endif

endmodule

// File: tb/tb_l4_cmd_fifo.sv
// Directed bench for l4_cmd_fifo; the almost-full expectations follow L4_CMD_FIFO_AFULL_EN.
module tb_l4_cmd_fifo;

`ifdef L4_CMD_FIFO_AFULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        host_wr;
    logic [31:0] host_data;
    logic        host_full;
    logic        host_afull;
    logic        flush;
    logic        cmd_empty;
    logic [31:0] cmd_data;
    logic        cmd_rd;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    l4_cmd_fifo #(.WIDTH(32), .ABITS(4), .AF_MARGIN(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .host_wr    (host_wr),
        .host_data  (host_data),
        .host_full  (host_full),
        .host_afull (host_afull),
        .flush      (flush),
        .cmd_empty  (cmd_empty),
        .cmd_data   (cmd_data),
        .cmd_rd     (cmd_rd),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_wr   = 1'b0;
        cmd_rd    = 1'b0;
        flush     = 1'b0;
        host_data = '0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #12;
        checks++;
        if ({cmd_empty, host_full, host_afull, overflow, underflow} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 10000", {cmd_empty, host_full, host_afull, overflow, underflow});
        end
        checks++;
        if (level !== 5'd0 || cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_level_data: got level=%0d data=%h exp 0/0", level, cmd_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        step();
        step();
        checks++;
        if (cmd_empty !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle: got empty=%b level=%0d exp 1/0", cmd_empty, level);
        end
    endtask

    task automatic test_single_write();
        host_wr   = 1'b1;
        host_data = 32'hA5A50001;
        step();
        idle_inputs();
        checks++;
        if (cmd_empty !== 1'b0 || cmd_data !== 32'hA5A50001 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_write: got empty=%b data=%h level=%0d exp 0/a5a50001/1", cmd_empty, cmd_data, level);
        end
        cmd_rd = 1'b1;
        step();
        cmd_rd = 1'b0;
        checks++;
        if (cmd_empty !== 1'b1 || cmd_data !== 32'h0 || level !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: got empty=%b data=%h level=%0d uf=%b exp 1/0/0/0", cmd_empty, cmd_data, level, underflow);
        end
    endtask

    task automatic test_fill_overflow();
        int bad;
        do_flush();
        for (int i = 0; i < 16; i++) begin
            host_wr   = 1'b1;
            host_data = 32'(i);
            step();
        end
        host_wr = 1'b0;
        checks++;
        if (host_full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill16: got full=%b level=%0d of=%b exp 1/16/0", host_full, level, overflow);
        end
        checks++;
        if (host_afull !== AF_ON) begin
            errors++;
            $display("FAIL afull_at_16: got %b exp %b", host_afull, AF_ON);
        end
        host_wr   = 1'b1;
        host_data = 32'hDEAD0000;
        step();
        host_wr = 1'b0;
        checks++;
        if (host_full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got full=%b level=%0d of=%b exp 1/16/1", host_full, level, overflow);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (cmd_data !== 32'(i) || cmd_empty !== 1'b0) begin
                bad++;
                $display("FAIL drain_word%0d: got %h empty=%b exp %h", i, cmd_data, cmd_empty, 32'(i));
            end
            cmd_rd = 1'b1;
            step();
        end
        cmd_rd = 1'b0;
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (cmd_empty !== 1'b1 || level !== 5'd0 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drained: got empty=%b level=%0d of=%b uf=%b exp 1/0/1/0", cmd_empty, level, overflow, underflow);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [31:0] exp_head;
        do_flush();
        for (int i = 0; i < 16; i++) begin
            host_wr   = 1'b1;
            host_data = 32'(i);
            step();
        end
        host_wr   = 1'b1;
        host_data = 32'h00000100;
        cmd_rd    = 1'b1;
        checks++;
        if (cmd_data !== 32'h0) begin
            errors++;
            $display("FAIL full_simul_pop: got %h exp 00000000", cmd_data);
        end
        step();
        idle_inputs();
        checks++;
        if (level !== 5'd15 || overflow !== 1'b1 || host_full !== 1'b0 || cmd_data !== 32'h1) begin
            errors++;
            $display("FAIL full_simul: got level=%0d of=%b full=%b head=%h exp 15/1/0/00000001", level, overflow, host_full, cmd_data);
        end
        cmd_rd = 1'b1;
        for (int i = 0; i < 7; i++) step();
        cmd_rd = 1'b0;
        checks++;
        if (level !== 5'd8 || cmd_data !== 32'h8) begin
            errors++;
            $display("FAIL level8: got level=%0d head=%h exp 8/00000008", level, cmd_data);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            exp_head  = (k < 8) ? 32'(8 + k) : 32'(32'h100 + (k - 8));
            if (cmd_data !== exp_head) begin
                bad++;
                $display("FAIL wrap_head%0d: got %h exp %h", k, cmd_data, exp_head);
            end
            host_wr   = 1'b1;
            cmd_rd    = 1'b1;
            host_data = 32'(32'h100 + k);
            step();
        end
        idle_inputs();
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (level !== 5'd8 || cmd_data !== 32'h10C) begin
            errors++;
            $display("FAIL wrap_end: got level=%0d head=%h exp 8/0000010c", level, cmd_data);
        end
    endtask

    task automatic test_underflow_flush();
        do_flush();
        cmd_rd = 1'b1;
        step();
        cmd_rd = 1'b0;
        checks++;
        if (underflow !== 1'b1 || level !== 5'd0 || cmd_empty !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got uf=%b level=%0d empty=%b of=%b exp 1/0/1/0", underflow, level, cmd_empty, overflow);
        end
        host_wr   = 1'b1;
        cmd_rd    = 1'b1;
        host_data = 32'h00000055;
        step();
        idle_inputs();
        checks++;
        if (level !== 5'd1 || cmd_data !== 32'h55 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL empty_simul: got level=%0d data=%h uf=%b exp 1/00000055/1", level, cmd_data, underflow);
        end
        flush     = 1'b1;
        host_wr   = 1'b1;
        cmd_rd    = 1'b1;
        host_data = 32'h00000077;
        step();
        idle_inputs();
        checks++;
        if (level !== 5'd0 || underflow !== 1'b0 || overflow !== 1'b0 || cmd_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_wr: got level=%0d uf=%b of=%b empty=%b exp 0/0/0/1", level, underflow, overflow, cmd_empty);
        end
        step();
        checks++;
        if (level !== 5'd0 || cmd_data !== 32'h0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_not_stored: got level=%0d data=%h uf=%b exp 0/0/0", level, cmd_data, underflow);
        end
    endtask

    task automatic test_afull();
        do_flush();
        for (int i = 0; i < 13; i++) begin
            host_wr   = 1'b1;
            host_data = 32'(i);
            step();
        end
        host_wr = 1'b0;
        checks++;
        if (host_afull !== 1'b0 || level !== 5'd13) begin
            errors++;
            $display("FAIL afull_13: got afull=%b level=%0d exp 0/13", host_afull, level);
        end
        host_wr   = 1'b1;
        host_data = 32'd13;
        step();
        host_wr = 1'b0;
        checks++;
        if (host_afull !== AF_ON || level !== 5'd14) begin
            errors++;
            $display("FAIL afull_14: got afull=%b level=%0d exp %b/14", host_afull, level, AF_ON);
        end
        cmd_rd = 1'b1;
        step();
        cmd_rd = 1'b0;
        checks++;
        if (host_afull !== 1'b0 || level !== 5'd13 || cmd_data !== 32'h1) begin
            errors++;
            $display("FAIL afull_pop: got afull=%b level=%0d head=%h exp 0/13/00000001", host_afull, level, cmd_data);
        end
    endtask

    task automatic test_reset_midburst();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            host_wr   = 1'b1;
            host_data = 32'hC0 + 32'(i);
            step();
        end
        cmd_rd = 1'b1;
        cmd_rd = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (level !== 5'd0 || cmd_empty !== 1'b1 || cmd_data !== 32'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: got level=%0d empty=%b data=%h of=%b exp 0/1/0/0", level, cmd_empty, cmd_data, overflow);
        end
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        step();
        checks++;
        if (level !== 5'd0 || cmd_empty !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: got level=%0d empty=%b exp 0/1", level, cmd_empty);
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_back_to_back();
        test_underflow_flush();
        test_afull();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
